// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
// Consumers: fetch_fifo, fetch_queue.
package fetch_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned INST_W = 26;
   localparam logic [ADDR_W-1:0] RESET_PC = '0;
   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1);

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [ADDR_W-1:0] pc;
   } fetch_entry_t;

   typedef enum logic {
      RUN,
      FULL
   } fq_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {inst, pc} entries; flush beats push and pop.
// The head reads as zero while the FIFO is empty.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  fetch_entry_t             wdata,
   output fetch_entry_t             head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !flush && push) mem[wr_ptr] <= wdata;
   end

   // The issue throttle reserves a slot for every in-flight read.
   always_ff @(posedge clk) begin
      if (!rst && !flush && push) assert (count < CW'(DEPTH));
   end

   assign head = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch front-end: PC register, synchronous ROM driver and prefetch buffer.
// Define FETCH_STATS_EN to add the stat_fetched / stat_flushed counters.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [INST_W-1:0] rom_q,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INST_W-1:0] out_inst,
   output logic [ADDR_W-1:0] out_pc
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]       stat_fetched,
   output logic [31:0]       stat_flushed
`endif
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pend_pc;
   logic              pending;
   fq_state_t         state;
   logic [CW-1:0]     count;
   logic [CW-1:0]     occ;
   logic [CW-1:0]     occ_next;
   logic              issue;
   logic              push;
   logic              pop;
   fetch_entry_t      wdata;
   fetch_entry_t      head;

   // state == RUN exactly when count + pending < DEPTH.
   assign occ      = count + CW'(pending);
   assign issue    = !rst && !redirect_valid && (state == RUN);
   assign push     = pending && !redirect_valid;
   assign pop      = out_valid && out_ready && !redirect_valid;
   assign occ_next = count + CW'(push) - CW'(pop) + CW'(issue);

   assign wdata    = '{inst: rom_q, pc: pend_pc};
   assign rom_addr = pc;

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .wdata (wdata),
      .head  (head),
      .count (count)
   );

   assign out_valid = (count != '0);
   assign out_inst  = head.inst;
   assign out_pc    = head.pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc      <= RESET_PC;
         pend_pc <= '0;
         pending <= 1'b0;
         state   <= RUN;
      end else if (redirect_valid) begin
         pc      <= redirect_pc;
         pending <= 1'b0;
         state   <= RUN;
      end else begin
         pending <= issue;
         if (issue) begin
            pend_pc <= pc;
            pc      <= pc + PC_STEP;
         end
         state <= (occ_next == CW'(DEPTH)) ? FULL : RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (occ <= CW'(DEPTH));
         assert ((state == RUN) == (occ < CW'(DEPTH)));
      end
   end

`ifdef FETCH_STATS_EN
   logic [32:0] flushed_sum;

   assign flushed_sum = {1'b0, stat_flushed} + 33'(occ);

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_fetched <= '0;
         stat_flushed <= '0;
      end else begin
         if (push && (stat_fetched != '1)) stat_fetched <= stat_fetched + 32'd1;
         if (redirect_valid) stat_flushed <= flushed_sum[32] ? '1 : flushed_sum[31:0];
      end
   end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue against a 1-cycle ROM model with ROM[a] = a + 0x100.
module tb_fetch_queue;
   import fetch_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic [ADDR_W-1:0] rom_addr;
   logic [INST_W-1:0] rom_q;
   logic              out_valid;
   logic              out_ready;
   logic [INST_W-1:0] out_inst;
   logic [ADDR_W-1:0] out_pc;

   int errors = 0;
   int checks = 0;

   fetch_queue #(
      .DEPTH (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .rom_addr       (rom_addr),
      .rom_q          (rom_q),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc)
`ifdef FETCH_STATS_EN
      ,
      .stat_fetched   (),
      .stat_flushed   ()
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_q <= INST_W'(rom_addr + 32'h100);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      out_ready      = 1'b1;
      step();

      // Reset state and streaming latency
      do_reset();
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_inst", 64'(out_inst), 64'd0);
      check("rst_pc", 64'(out_pc), 64'd0);
      check("rst_addr", 64'(rom_addr), 64'd0);
      step();
      check("c1_valid", 64'(out_valid), 64'd0);
      check("c1_addr", 64'(rom_addr), 64'd1);
      for (int k = 0; k < 6; k++) begin
         step();
         check("stream_valid", 64'(out_valid), 64'd1);
         check("stream_pc", 64'(out_pc), 64'(k));
         check("stream_inst", 64'(out_inst), 64'(26'h100 + 26'(k)));
         check("stream_addr", 64'(rom_addr), 64'(k + 2));
      end

      // Stall from cycle 0 until full, then drain with no gap or duplicate
      out_ready = 1'b0;
      do_reset();
      check("rst2_valid", 64'(out_valid), 64'd0);
      check("rst2_addr", 64'(rom_addr), 64'd0);
      for (int k = 0; k < 6; k++) step();
      check("full_addr", 64'(rom_addr), 64'd4);
      check("full_valid", 64'(out_valid), 64'd1);
      check("full_pc", 64'(out_pc), 64'd0);
      check("full_inst", 64'(out_inst), 64'h100);
      out_ready = 1'b1;
      for (int k = 1; k < 7; k++) begin
         step();
         check("drain_valid", 64'(out_valid), 64'd1);
         check("drain_pc", 64'(out_pc), 64'(k));
         check("drain_inst", 64'(out_inst), 64'(26'h100 + 26'(k)));
      end

      // Redirect with 3 buffered + 1 pending
      out_ready = 1'b0;
      do_reset();
      for (int k = 0; k < 4; k++) step();
      check("pre_redir_addr", 64'(rom_addr), 64'd4);
      check("pre_redir_valid", 64'(out_valid), 64'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      step();
      redirect_valid = 1'b0;
      check("redir_valid", 64'(out_valid), 64'd0);
      check("redir_addr", 64'(rom_addr), 64'h40);
      step();
      check("redir1_valid", 64'(out_valid), 64'd0);
      check("redir1_addr", 64'(rom_addr), 64'h41);
      step();
      check("redir2_valid", 64'(out_valid), 64'd1);
      check("redir2_pc", 64'(out_pc), 64'h40);
      check("redir2_inst", 64'(out_inst), 64'h140);
      step();
      check("hold_pc", 64'(out_pc), 64'h40);
      check("hold_inst", 64'(out_inst), 64'h140);

      // Fill, then redirect with out_ready=1 to the top of the address space
      for (int k = 0; k < 4; k++) step();
      check("fill_addr", 64'(rom_addr), 64'h44);
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFF;
      out_ready      = 1'b1;
      step();
      redirect_valid = 1'b0;
      check("wrap_r_valid", 64'(out_valid), 64'd0);
      check("wrap_r_addr", 64'(rom_addr), 64'hFFFF_FFFF);
      step();
      check("wrap1_valid", 64'(out_valid), 64'd0);
      check("wrap1_addr", 64'(rom_addr), 64'd0);
      step();
      check("wrap2_valid", 64'(out_valid), 64'd1);
      check("wrap2_pc", 64'(out_pc), 64'hFFFF_FFFF);
      check("wrap2_inst", 64'(out_inst), 64'h0FF);
      step();
      check("wrap3_pc", 64'(out_pc), 64'd0);
      check("wrap3_inst", 64'(out_inst), 64'h100);

      // Back-to-back redirects: the last one wins
      redirect_valid = 1'b1;
      redirect_pc    = 32'h10;
      step();
      redirect_pc = 32'h20;
      step();
      redirect_valid = 1'b0;
      check("b2b_valid", 64'(out_valid), 64'd0);
      check("b2b_addr", 64'(rom_addr), 64'h20);
      step();
      step();
      check("b2b_pc", 64'(out_pc), 64'h20);
      check("b2b_inst", 64'(out_inst), 64'h120);
      step();
      check("b2b_next_pc", 64'(out_pc), 64'h21);

      // Reset mid-stream with a simultaneous redirect: reset wins
      out_ready = 1'b0;
      step();
      step();
      check("mid_valid", 64'(out_valid), 64'd1);
      rst            = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h77;
      step();
      check("midrst_valid", 64'(out_valid), 64'd0);
      check("midrst_addr", 64'(rom_addr), 64'd0);
      rst            = 1'b0;
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      step();
      check("restart1_valid", 64'(out_valid), 64'd0);
      check("restart1_addr", 64'(rom_addr), 64'd1);
      step();
      check("restart2_valid", 64'(out_valid), 64'd1);
      check("restart2_pc", 64'(out_pc), 64'd0);
      check("restart2_inst", 64'(out_inst), 64'h100);
      step();
      check("restart3_pc", 64'(out_pc), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
